iram_responder: RTL and testbench

IRAM_RESPONDER -- requirements
Module: iram_responder

---
 rtl/iram_pkg.sv | 14 +
 rtl/lfsr16.sv | 19 +
 rtl/iram_responder.sv | 103 ++++++++++
 tb/tb_iram_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/iram_pkg.sv
// Shared types and constants for the instruction-RAM responder.
package iram_pkg;
    localparam int          XLEN      = 32;
    localparam int          WAIT_MAX  = 15;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;
endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used to inject pseudo-random back-pressure.
module lfsr16
    import iram_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] o_lfsr
);
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb   = ^(r_lfsr & LFSR_TAPS);
    assign o_lfsr = r_lfsr;

    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= LFSR_SEED;
        else     r_lfsr <= {r_lfsr[14:0], w_fb};
    end
endmodule

// File: rtl/iram_responder.sv
// Word-addressed RAM responder with configurable wait states and byte-strobed writes.
// Define IRAM_STALL_EN to add LFSR-driven random ready stalls.
module iram_responder
    import iram_pkg::*;
#(
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iram_req,
    input  logic              iram_write,
    input  logic [XLEN/8-1:0] iram_wstrb,
    input  logic [XLEN-1:0]   iram_addr,
    input  logic [XLEN-1:0]   iram_wdata,
    output logic              iram_ready,
    output logic              iram_rvalid,
    output logic [XLEN-1:0]   iram_rdata
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int NB = XLEN / 8;

    logic [XLEN-1:0] r_mem [DEPTH];
    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_inc;
    logic [AW-1:0]   r_idx, w_idx, w_rd_idx;
    logic            r_is_rd, r_rvalid;
    logic [XLEN-1:0] r_rdata;
    logic            w_stall, w_ready, w_acc, w_wait_done, w_load;
    logic            w_unused_addr;

    assign w_idx         = iram_addr[AW+1:2];
    assign w_unused_addr = ^{iram_addr[XLEN-1:AW+2], iram_addr[1:0]};
    assign w_cnt_inc     = r_cnt + 1'b1;
    assign w_wait_done   = (r_state == WAIT) && (w_cnt_inc == CW'(WAIT_CYCLES));
    assign w_ready       = !rst && !w_stall && (r_state != WAIT);
    assign w_acc         = iram_req && w_ready;

    // Zero-wait reads fetch at the acceptance edge; otherwise at the WAIT->RESP edge.
    assign w_load   = (WAIT_CYCLES == 0) ? (w_acc && !iram_write) : (w_wait_done && r_is_rd);
    assign w_rd_idx = (WAIT_CYCLES == 0) ? w_idx : r_idx;

`ifdef IRAM_STALL_EN
    logic [15:0] w_lfsr;
    logic        w_unused_lfsr;

    lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .o_lfsr (w_lfsr)
    );
    assign w_stall       = w_lfsr[0];
    assign w_unused_lfsr = ^w_lfsr[15:1];
`else
    assign w_stall = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_acc && (WAIT_CYCLES > 0)) w_state_nxt = WAIT;
            WAIT:    if (w_wait_done) w_state_nxt = RESP;
            RESP:    w_state_nxt = w_acc ? WAIT : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_is_rd  <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_rvalid <= w_load;
            if (w_load) r_rdata <= r_mem[w_rd_idx];
            if (w_acc) begin
                r_cnt   <= '0;
                r_idx   <= w_idx;
                r_is_rd <= !iram_write;
            end else if (r_state == WAIT) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_acc && iram_write) begin
            for (int b = 0; b < NB; b++) begin
                if (iram_wstrb[b]) r_mem[w_idx][8*b +: 8] <= iram_wdata[8*b +: 8];
            end
        end
    end

    assign iram_ready  = w_ready;
    assign iram_rvalid = r_rvalid;
    assign iram_rdata  = r_rdata;
endmodule

// File: tb/tb_iram_responder.sv
// Directed bench: a zero-wait and a three-wait instance; random stall run under IRAM_STALL_EN.
module tb_iram_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        a_req, a_write, a_ready, a_rvalid;
    logic [3:0]  a_wstrb;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        b_req, b_write, b_ready, b_rvalid;
    logic [3:0]  b_wstrb;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [31:0] b_last;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    iram_responder #(.DEPTH(4096), .WAIT_CYCLES(0)) u_a (
        .clk(clk), .rst(rst), .iram_req(a_req), .iram_write(a_write), .iram_wstrb(a_wstrb),
        .iram_addr(a_addr), .iram_wdata(a_wdata), .iram_ready(a_ready),
        .iram_rvalid(a_rvalid), .iram_rdata(a_rdata)
    );

    iram_responder #(.DEPTH(4096), .WAIT_CYCLES(3)) u_b (
        .clk(clk), .rst(rst), .iram_req(b_req), .iram_write(b_write), .iram_wstrb(b_wstrb),
        .iram_addr(b_addr), .iram_wdata(b_wdata), .iram_ready(b_ready),
        .iram_rvalid(b_rvalid), .iram_rdata(b_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic a_drive(input logic req, input logic wr, input logic [3:0] strb,
                           input logic [31:0] addr, input logic [31:0] data);
        a_req = req; a_write = wr; a_wstrb = strb; a_addr = addr; a_wdata = data;
    endtask

    // One request on the 3-wait instance: 3 stalled cycles, then RESP.
    // With noise, a write to 0x24 is held on the bus during the stall and must be ignored.
    task automatic b_txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] exp, input logic noise);
        b_req = 1'b1; b_write = wr; b_wstrb = 4'hF; b_addr = addr; b_wdata = data;
        tick;
        if (noise) begin
            b_write = 1'b1; b_addr = 32'h24; b_wdata = 32'hFFFF_FFFF;
        end else begin
            b_req = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            chk("b_wait_ready", b_ready, 1'b0);
            chk("b_wait_rvalid", b_rvalid, 1'b0);
            chk("b_wait_rdata_hold", b_rdata, b_last);
            tick;
        end
        b_req = 1'b0;
        chk("b_resp_ready", b_ready, 1'b1);
        chk("b_resp_rvalid", b_rvalid, !wr);
        if (!wr) begin
            b_last = exp;
            chk("b_resp_rdata", b_rdata, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [3:0] w);
        return 32'hA55A_0000 + 32'(w) * 32'h0000_0101;
    endfunction

    initial begin
        rst = 1'b1;
        a_drive(0, 0, 4'h0, 32'h0, 32'h0);
        b_req = 1'b0; b_write = 1'b0; b_wstrb = 4'h0; b_addr = 32'h0; b_wdata = 32'h0;
        b_last = 32'h0;
        tick; tick;
        chk("rst_a_ready", a_ready, 1'b0);
        chk("rst_a_rvalid", a_rvalid, 1'b0);
        chk("rst_a_rdata", a_rdata, 32'h0);
        chk("rst_b_ready", b_ready, 1'b0);
        chk("rst_b_rdata", b_rdata, 32'h0);
        rst = 1'b0;
        #1;
`ifdef IRAM_STALL_EN
        begin
            logic       rdy;
            logic [3:0] w;
            int         g, acc, cyc, low_seen;
            acc = 0; cyc = 0; low_seen = 0;
            for (int i = 0; i < 16; i++) begin
                a_drive(1, 1, 4'hF, 32'(i) << 2, model_word(4'(i)));
                g = 0;
                do begin
                    rdy = a_ready;
                    tick;
                    g++;
                end while (!rdy && g < 100);
                chk("stall_preload_accept", rdy, 1'b1);
            end
            while (acc < 1000 && cyc < 20000) begin
                w = 4'($urandom_range(0, 15));
                a_drive(1, 0, 4'h0, (32'(w) << 2) | (32'($urandom_range(0, 3)) << 14), 32'h0);
                rdy = a_ready;
                if (!rdy) low_seen++;
                tick;
                cyc++;
                chk("stall_rvalid", a_rvalid, rdy);
                if (rdy) begin
                    chk("stall_rdata", a_rdata, model_word(w));
                    acc++;
                end
            end
            a_drive(0, 0, 4'h0, 32'h0, 32'h0);
            tick;
            chk("stall_tail_rvalid", a_rvalid, 1'b0);
            chk("stall_read_count", acc, 1000);
            chk("stall_ready_low_seen", low_seen > 0, 1'b1);
        end
`else
        chk("post_rst_a_ready", a_ready, 1'b1);
        chk("post_rst_b_ready", b_ready, 1'b1);

        // zero-wait: write, then read the next cycle
        a_drive(1, 1, 4'hF, 32'h100, 32'hDEAD_BEEF); tick;
        chk("a_write_no_rvalid", a_rvalid, 1'b0);
        chk("a_ready_b2b", a_ready, 1'b1);
        a_drive(1, 0, 4'h0, 32'h100, 32'h0); tick;
        chk("a_read_rvalid", a_rvalid, 1'b1);
        chk("a_read_rdata", a_rdata, 32'hDEAD_BEEF);
        a_drive(0, 0, 4'h0, 32'h0, 32'h0); tick;
        chk("a_idle_rvalid", a_rvalid, 1'b0);
        chk("a_idle_rdata_hold", a_rdata, 32'hDEAD_BEEF);

        // partial writes, low and high byte
        a_drive(1, 1, 4'b0001, 32'h100, 32'h0000_00AA); tick;
        a_drive(1, 0, 4'h0, 32'h100, 32'h0); tick;
        chk("a_partial_rvalid", a_rvalid, 1'b1);
        chk("a_partial_rdata", a_rdata, 32'hDEAD_BEAA);

        // wrap: 0x4000 aliases word 0; low address bits ignored
        a_drive(1, 1, 4'hF, 32'h4000, 32'h1234_5678); tick;
        a_drive(1, 0, 4'h0, 32'h0000, 32'h0); tick;
        chk("a_wrap_rdata", a_rdata, 32'h1234_5678);
        a_drive(1, 1, 4'b1000, 32'h0002, 32'h5500_0000); tick;
        chk("a_wr_after_rd_rvalid", a_rvalid, 1'b0);
        chk("a_wr_after_rd_hold", a_rdata, 32'h1234_5678);
        a_drive(1, 0, 4'h0, 32'h4003, 32'h0); tick;
        chk("a_hi_byte_rvalid", a_rvalid, 1'b1);
        chk("a_hi_byte_rdata", a_rdata, 32'h5534_5678);
        a_drive(1, 0, 4'h0, 32'h100, 32'h0); tick;
        chk("a_b2b_rvalid", a_rvalid, 1'b1);
        chk("a_b2b_rdata", a_rdata, 32'hDEAD_BEAA);
        a_drive(0, 0, 4'h0, 32'h0, 32'h0); tick;
        chk("a_end_rvalid", a_rvalid, 1'b0);

        // three wait states, requests issued back-to-back in RESP
        b_txn(1, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0);
        b_txn(1, 32'h24, 32'h1122_3344, 32'h0, 1'b0);
        b_txn(0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b1);
        b_txn(0, 32'h24, 32'h0, 32'h1122_3344, 1'b0);
        tick;
        chk("b_idle_ready", b_ready, 1'b1);
        chk("b_idle_rvalid", b_rvalid, 1'b0);
        chk("b_idle_rdata_hold", b_rdata, 32'h1122_3344);

        // reset during WAIT drops the read
        b_req = 1'b1; b_write = 1'b0; b_addr = 32'h20;
        tick;
        b_req = 1'b0;
        chk("b_mid_wait_ready", b_ready, 1'b0);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        b_last = 32'h0;
        chk("b_after_rst_ready", b_ready, 1'b1);
        chk("b_after_rst_rvalid", b_rvalid, 1'b0);
        chk("b_after_rst_rdata", b_rdata, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("b_no_late_rvalid", b_rvalid, 1'b0);
        end
        // memory survives reset
        b_txn(0, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
